mod_hazard: RTL and testbench

Forwarding and hazard-detection unit for the five-stage 16-bit pipeline. It tracks the destination register, write enable and load flag of the instructions in EX, MEM and WB, and drives the `forward_aluin1`/`forward_aluin2` selects consumed by the execution stage. It also raises a one-cycle load-use stall and keeps a saturating stall counter for performance monitoring. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and advances in lockstep with them.

---
 rtl/mod_hazard.sv | 135 +++++++++++++
 tb/tb_mod_hazard.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_hazard.sv
// mod_hazard: forwarding and load-use hazard unit for the five-stage 16-bit
// pipeline. Shadows the register-usage fields of the instructions in EX, MEM
// and WB, and advances in lockstep with the pipeline registers.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   hold                global freeze: tracking entries and counter keep state
//   flush               branch redirect: the ID instruction becomes a bubble
//   id_rs/id_rt         ID source registers, qualified by id_uses_rs/id_uses_rt
//   id_rd/id_regwrite   ID destination register and its write enable
//   id_memread          ID instruction is a load
//   forward_aluin1/2    EX ALU operand select: 00 regfile, 01 MEM, 10 WB
//   stall               load-use stall: freeze PC and IF/ID, bubble into ID/EX
//   stall_count         saturating count of stall cycles taken
module mod_hazard (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [3:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    output logic [1:0]  forward_aluin1,
    output logic [1:0]  forward_aluin2,
    output logic        stall,
    output logic [15:0] stall_count
);

    // EX entry
    logic [3:0]  ex_rs;
    logic [3:0]  ex_rt;
    logic [3:0]  ex_rd;
    logic        ex_uses_rs;
    logic        ex_uses_rt;
    logic        ex_regwrite;
    logic        ex_memread;
    // MEM entry
    logic [3:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_memread;
    // WB entry
    logic [3:0]  wb_rd;
    logic        wb_regwrite;

    logic [15:0] stall_cnt;
    logic        load_in_ex;
    logic        insert_bubble;

    // MEM holds the younger producer, so it is checked first. A load in MEM
    // never forwards: its data is not ready and the stall prevents that case.
    function automatic logic [1:0] fwd_sel(
        input logic       uses,
        input logic [3:0] src,
        input logic       m_wr,
        input logic       m_ld,
        input logic [3:0] m_rd,
        input logic       w_wr,
        input logic [3:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && (src != 4'd0)) begin
            if (m_wr && !m_ld && (m_rd == src))
                sel = 2'b01;
            else if (w_wr && (w_rd == src))
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        forward_aluin1 = fwd_sel(ex_uses_rs, ex_rs, mem_regwrite, mem_memread,
                                 mem_rd, wb_regwrite, wb_rd);
        forward_aluin2 = fwd_sel(ex_uses_rt, ex_rt, mem_regwrite, mem_memread,
                                 mem_rd, wb_regwrite, wb_rd);
    end

    always_comb begin
        load_in_ex    = ex_memread && ex_regwrite && (ex_rd != 4'd0);
        stall         = !flush && load_in_ex &&
                        ((id_uses_rs && (id_rs == ex_rd)) ||
                         (id_uses_rt && (id_rt == ex_rd)));
        insert_bubble = stall || flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_uses_rs   <= 1'b0;
            ex_uses_rt   <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            stall_cnt    <= '0;
        end else if (!hold) begin
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            if (insert_bubble) begin
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_rd       <= '0;
                ex_uses_rs  <= 1'b0;
                ex_uses_rt  <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_rd       <= id_rd;
                ex_uses_rs  <= id_uses_rs;
                ex_uses_rt  <= id_uses_rt;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_count = stall_cnt;

endmodule

// File: tb/tb_mod_hazard.sv
module tb_mod_hazard;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [3:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic [1:0]  forward_aluin1;
    logic [1:0]  forward_aluin2;
    logic        stall;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; all-zero is a bubble.
    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic       urs;
        logic       urt;
        logic       wr;
        logic       ld;
    } ins_t;

    ins_t        pipe [3];
    int unsigned m_cnt;

    always #5 clk = ~clk;

    mod_hazard dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .flush          (flush),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_rd          (id_rd),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .forward_aluin1 (forward_aluin1),
        .forward_aluin2 (forward_aluin2),
        .stall          (stall),
        .stall_count    (stall_count)
    );

    function automatic ins_t cur_id();
        ins_t t;
        t.rs  = id_rs;
        t.rt  = id_rt;
        t.rd  = id_rd;
        t.urs = id_uses_rs;
        t.urt = id_uses_rt;
        t.wr  = id_regwrite;
        t.ld  = id_memread;
        return t;
    endfunction

    // Search older stages youngest-first for the producer of the operand.
    function automatic logic [1:0] model_fwd(input bit second);
        logic [3:0] src;
        logic       used;
        src  = second ? pipe[0].rt  : pipe[0].rs;
        used = second ? pipe[0].urt : pipe[0].urs;
        if (!used || src == 4'd0) return 2'b00;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].wr && pipe[s].rd == src && !(s == 1 && pipe[s].ld))
                return 2'(s);
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        ins_t e;
        e = pipe[0];
        if (flush || !e.ld || !e.wr || e.rd == 4'd0) return 1'b0;
        return (id_uses_rs && id_rs == e.rd) || (id_uses_rt && id_rt == e.rd);
    endfunction

    task automatic tick();
        logic st;
        st = model_stall();
        @(posedge clk);
        if (!hold) begin
            if (st && m_cnt < 65535) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (st || flush) ? ins_t'('0) : cur_id();
        end
        #1;
    endtask

    task automatic set_id(input logic [3:0] rs, input logic urs, input logic [3:0] rt,
                          input logic urt, input logic [3:0] rd, input logic wr,
                          input logic ld);
        id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_regwrite = wr; id_memread = ld;
    endtask

    task automatic nop();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        nop();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_cnt = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (forward_aluin1 !== 2'b00) begin bad++; $display("FAIL reset_fwd1 got=%b exp=00", forward_aluin1); end
        total++; if (forward_aluin2 !== 2'b00) begin bad++; $display("FAIL reset_fwd2 got=%b exp=00", forward_aluin2); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (stall_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", stall_count); end
    endtask

    task automatic test_ex_forward();
        do_reset();
        set_id(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);   // ADD R3,R1,R2
        tick();
        set_id(4'd3, 1'b1, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0);   // SUB R6,R3,R4
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL exfwd_stall_id got=%b exp=0", stall); end
        tick();
        nop();
        #1;
        total++; if (forward_aluin1 !== 2'b01) begin bad++; $display("FAIL exfwd_fwd1 got=%b exp=01", forward_aluin1); end
        total++; if (forward_aluin2 !== 2'b00) begin bad++; $display("FAIL exfwd_fwd2 got=%b exp=00", forward_aluin2); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL exfwd_stall_ex got=%b exp=0", stall); end
    endtask

    task automatic test_wb_forward();
        do_reset();
        set_id(4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);   // ADD R5
        tick();
        nop();
        tick();
        set_id(4'd6, 1'b1, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0);   // AND R7,R6,R5
        tick();
        nop();
        #1;
        total++; if (forward_aluin2 !== 2'b10) begin bad++; $display("FAIL wbfwd_fwd2 got=%b exp=10", forward_aluin2); end
        total++; if (forward_aluin1 !== 2'b00) begin bad++; $display("FAIL wbfwd_fwd1 got=%b exp=00", forward_aluin1); end

        do_reset();
        set_id(4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);   // ADD R5
        tick();
        set_id(4'd1, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0);   // ADD R5 again
        tick();
        set_id(4'd6, 1'b1, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0);   // AND R7,R6,R5
        tick();
        nop();
        #1;
        total++; if (forward_aluin2 !== 2'b01) begin bad++; $display("FAIL prio_fwd2 got=%b exp=01", forward_aluin2); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);   // LW R2
        tick();
        set_id(4'd2, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD R4,R2,R3
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL lu_count0 got=%h exp=0000", stall_count); end
        tick();
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", stall); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_count1 got=%h exp=0001", stall_count); end
        total++; if (forward_aluin1 !== 2'b00) begin bad++; $display("FAIL lu_bubble_fwd1 got=%b exp=00", forward_aluin1); end
        tick();
        nop();
        #1;
        total++; if (forward_aluin1 !== 2'b10) begin bad++; $display("FAIL lu_fwd1 got=%b exp=10", forward_aluin1); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_count_hold got=%h exp=0001", stall_count); end
    endtask

    task automatic test_r0();
        do_reset();
        set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);   // LW R0
        tick();
        set_id(4'd0, 1'b1, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0);   // ADD reading R0
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall); end
        tick();
        set_id(4'd1, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0);   // producer of R4
        #1;
        total++; if (forward_aluin1 !== 2'b00) begin bad++; $display("FAIL r0_fwd1 got=%b exp=00", forward_aluin1); end
        total++; if (forward_aluin2 !== 2'b00) begin bad++; $display("FAIL r0_fwd2 got=%b exp=00", forward_aluin2); end
        tick();
        set_id(4'd4, 1'b0, 4'd4, 1'b0, 4'd6, 1'b1, 1'b0);   // names R4 but reads nothing
        tick();
        nop();
        #1;
        total++; if (forward_aluin1 !== 2'b00) begin bad++; $display("FAIL nouse_fwd1 got=%b exp=00", forward_aluin1); end
        total++; if (forward_aluin2 !== 2'b00) begin bad++; $display("FAIL nouse_fwd2 got=%b exp=00", forward_aluin2); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);   // LW R2
        tick();
        set_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);   // LW R5,(R2) while flushed
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
        tick();
        flush = 1'b0;
        set_id(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);   // reader of R5
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%b exp=0", stall); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL flush_count got=%h exp=0000", stall_count); end
    endtask

    task automatic test_hold();
        do_reset();
        set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);   // LW R2
        tick();
        set_id(4'd2, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD R4,R2,R3
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL hold_stall%0d got=%b exp=1", i, stall); end
            total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL hold_count%0d got=%h exp=0000", i, stall_count); end
            tick();
        end
        hold = 1'b0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL hold_release got=%b exp=1", stall); end
        tick();
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL hold_after got=%b exp=0", stall); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL hold_count got=%h exp=0001", stall_count); end
        tick();
        nop();
        #1;
        total++; if (forward_aluin1 !== 2'b10) begin bad++; $display("FAIL hold_fwd1 got=%b exp=10", forward_aluin1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);   // LW R2
        tick();
        set_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);   // ADD reading R2
        tick();
        set_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);   // LW R3,(R2)
        tick();
        set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);   // ADD reading R3
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ar_pre_stall got=%b exp=1", stall); end
        total++; if (forward_aluin1 !== 2'b10) begin bad++; $display("FAIL ar_pre_fwd1 got=%b exp=10", forward_aluin1); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL ar_pre_count got=%h exp=0001", stall_count); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ar_stall got=%b exp=0", stall); end
        total++; if (forward_aluin1 !== 2'b00) begin bad++; $display("FAIL ar_fwd1 got=%b exp=00", forward_aluin1); end
        total++; if (forward_aluin2 !== 2'b00) begin bad++; $display("FAIL ar_fwd2 got=%b exp=00", forward_aluin2); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL ar_count got=%h exp=0000", stall_count); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_cnt = 0;
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFE;
        total++; if (stall_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", stall_count); end
        for (int i = 0; i < 3; i++) begin
            set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);   // LW R2
            tick();
            set_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);   // ADD reading R2
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall%0d got=%b exp=1", i, stall); end
            tick();
            #1;
            total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count%0d got=%h exp=ffff", i, stall_count); end
        end
        nop();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id(4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 2) == 0));
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            #1;
            total++; if (forward_aluin1 !== model_fwd(1'b0)) begin bad++; $display("FAIL rnd_fwd1 cyc=%0d got=%b exp=%b", i, forward_aluin1, model_fwd(1'b0)); end
            total++; if (forward_aluin2 !== model_fwd(1'b1)) begin bad++; $display("FAIL rnd_fwd2 cyc=%0d got=%b exp=%b", i, forward_aluin2, model_fwd(1'b1)); end
            total++; if (stall !== model_stall()) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, model_stall()); end
            total++; if (stall_count !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%h exp=%h", i, stall_count, 16'(m_cnt)); end
            tick();
        end
        hold  = 1'b0;
        flush = 1'b0;
        nop();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        nop();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_cnt = 0;
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_r0();
        test_flush();
        test_hold();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
